// File: rtl/conv_pkg.sv
// Shared types and widths for the CNN window sequencer: FSM state encoding,
// pixel/adder/window-sum widths and the adder-to-accumulator extension helper.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int ADD_W  = 10;
  localparam int SUM_W  = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_ISSUE1,
    S_ISSUE2,
    S_WAIT,
    S_OUT,
    S_DONE
  } conv_state_t;

  // Row sums are unsigned; 9*255 fits in SUM_W so plain zero-extension is exact.
  function automatic logic [SUM_W-1:0] zext_sum(input logic [ADD_W-1:0] v);
    return {{(SUM_W-ADD_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/conv_win_cnt.sv
// Window-origin counters (row r, column c) for a row-major 3x3 scan,
// with clear, advance and a flag marking the bottom-right window.
module conv_win_cnt #(
  parameter  int IMG_W = 6,
  parameter  int IMG_H = 6,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 3);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/conv_window_seq.sv
// 3x3 window sequencer: issues three register-file row reads per window,
// accumulates the registered adder's row sums and offers the window sum downstream.
module conv_window_seq import conv_pkg::*; #(
  parameter  int IMG_W = 6,
  parameter  int IMG_H = 6,
  localparam int RW    = $clog2(IMG_H),
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rf_rd_en,
  output logic [RW-1:0]    rf_row,
  output logic [CW-1:0]    rf_col,
  input  logic [ADD_W-1:0] adder_sum,
  output logic [SUM_W-1:0] out_data,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             out_valid,
  input  logic             out_ready
);

  conv_state_t      state, state_nxt;
  logic [SUM_W-1:0] acc;
  logic [RW-1:0]    win_row, row_off, row_live, row_hold;
  logic [CW-1:0]    win_col, col_hold;
  logic             win_last, xfer, cnt_clr;

  assign xfer    = (state == S_OUT) && out_ready && !abort;
  assign cnt_clr = (state == S_IDLE) && start;

  conv_win_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .adv  (xfer),
    .row  (win_row),
    .col  (win_col),
    .last (win_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rf_rd_en  = 1'b0;
    row_off   = '0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_ISSUE0;
      S_ISSUE0: begin rf_rd_en = 1'b1; row_off = RW'(0); state_nxt = S_ISSUE1; end
      S_ISSUE1: begin rf_rd_en = 1'b1; row_off = RW'(1); state_nxt = S_ISSUE2; end
      S_ISSUE2: begin rf_rd_en = 1'b1; row_off = RW'(2); state_nxt = S_WAIT;   end
      S_WAIT:   state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = win_last ? S_DONE : S_ISSUE0;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  assign row_live = win_row + row_off;

  // Read address is live while issuing and otherwise replays the last one issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_hold <= '0;
      col_hold <= '0;
    end else if (rf_rd_en) begin
      row_hold <= row_live;
      col_hold <= win_col;
    end
  end

  assign rf_row = rf_rd_en ? row_live : row_hold;
  assign rf_col = rf_rd_en ? win_col  : col_hold;

  // Adder output trails each issue by one cycle: ISSUE1/ISSUE2/WAIT see rows 0/1/2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else begin
      unique case (state)
        S_ISSUE1:       acc <= zext_sum(adder_sum);
        S_ISSUE2, S_WAIT: acc <= acc + zext_sum(adder_sum);
        default:        acc <= acc;
      endcase
    end
  end

  assign out_data = acc;
  assign out_row  = win_row;
  assign out_col  = win_col;

endmodule

// File: tb/tb_conv_window_seq.sv
// Bench for conv_window_seq: 4x4 and 3x3 instances, register-file/adder
// environment, window-sum scoreboard built from the image with plain loops.
module tb_conv_window_seq;

  typedef struct {
    int sum;
    int r;
    int c;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  int img [0:3][0:3];

  // 4x4 instance
  logic        a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b1;
  logic        a_busy, a_done, a_rd, a_valid;
  logic [1:0]  a_row, a_col, a_orow, a_ocol;
  logic [9:0]  a_sum = '0;
  logic [11:0] a_data;

  // 3x3 instance
  logic        b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
  logic        b_busy, b_done, b_rd, b_valid;
  logic [1:0]  b_row, b_col, b_orow, b_ocol;
  logic [9:0]  b_sum = '0;
  logic [11:0] b_data;

  conv_window_seq #(.IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .rf_rd_en(a_rd), .rf_row(a_row), .rf_col(a_col),
    .adder_sum(a_sum), .out_data(a_data), .out_row(a_orow), .out_col(a_ocol),
    .out_valid(a_valid), .out_ready(a_ready)
  );

  conv_window_seq #(.IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .rf_rd_en(b_rd), .rf_row(b_row), .rf_col(b_col),
    .adder_sum(b_sum), .out_data(b_data), .out_row(b_orow), .out_col(b_ocol),
    .out_valid(b_valid), .out_ready(b_ready)
  );

  // Register file plus registered 3-input adder
  always @(posedge clk) begin
    if (a_rd)
      a_sum <= 10'(img[int'(a_row)][int'(a_col)] + img[int'(a_row)][int'(a_col)+1] +
                   img[int'(a_row)][int'(a_col)+2]);
    if (b_rd)
      b_sum <= 10'(img[int'(b_row)][int'(b_col)] + img[int'(b_row)][int'(b_col)+1] +
                   img[int'(b_row)][int'(b_col)+2]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int win_sum(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += img[r+i][c+j];
    return s;
  endfunction

  win_t aq[$];
  win_t bq[$];
  int a_xfers = 0, a_done_cnt = 0;
  int b_xfers = 0, b_done_cnt = 0, b_xfer_cyc = -1, b_done_cyc = -1;

  task automatic build_a();
    aq.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        win_t e;
        e.sum = win_sum(r, c);
        e.r   = r;
        e.c   = c;
        aq.push_back(e);
      end
  endtask

  task automatic set_img(input int mode);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        img[r][c] = (mode == 0) ? 255 : 4 * r + c;
  endtask

  // Scoreboards: compare whenever a window is offered, retire it on transfer
  always @(negedge clk) begin
    if (a_done) a_done_cnt++;
    if (a_valid) begin
      if (aq.size() == 0) check("a_unexpected_window", 1, 0);
      else begin
        check("a_out_data", 32'(a_data), aq[0].sum);
        check("a_out_row", 32'(a_orow), aq[0].r);
        check("a_out_col", 32'(a_ocol), aq[0].c);
        check("a_rd_during_out", 32'(a_rd), 0);
        if (a_ready) begin
          aq.delete(0);
          a_xfers++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_done) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
    if (b_valid) begin
      if (bq.size() == 0) check("b_unexpected_window", 1, 0);
      else begin
        check("b_out_data", 32'(b_data), bq[0].sum);
        check("b_out_row", 32'(b_orow), bq[0].r);
        check("b_out_col", 32'(b_ocol), bq[0].c);
        if (b_ready) begin
          bq.delete(0);
          b_xfers++;
          b_xfer_cyc = cyc;
        end
      end
    end
  end

  task automatic pulse_a_start();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic wait_a_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (a_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check(name, 0, 1);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_busy"}, 32'(a_busy), 0);
    check({tag, "_done"}, 32'(a_done), 0);
    check({tag, "_rd"}, 32'(a_rd), 0);
    check({tag, "_rf_row"}, 32'(a_row), 0);
    check({tag, "_rf_col"}, 32'(a_col), 0);
    check({tag, "_valid"}, 32'(a_valid), 0);
    check({tag, "_data"}, 32'(a_data), 0);
    check({tag, "_orow"}, 32'(a_orow), 0);
    check({tag, "_ocol"}, 32'(a_ocol), 0);
  endtask

  initial begin
    int n, dc0;
    bit seen;
    set_img(0);
    repeat (3) @(posedge clk);
    #1 check_a_reset("rst");
    check("b_rst_valid", 32'(b_valid), 0);
    rst = 1'b0;

    // All bytes 255: four windows of 2295, first offer five cycles after start
    build_a();
    check("model_size_4x4", aq.size(), 4);
    check("model_255", aq[0].sum, 2295);
    dc0 = a_done_cnt;
    pulse_a_start();
    n = 1;
    while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("first_valid_cycle", n, 5);
    wait_a_done("ones_done_timeout", 100);
    @(posedge clk); #1;
    check("ones_xfers", a_xfers, 4);
    check("ones_done_once", a_done_cnt - dc0, 1);
    check("ones_done_cleared", 32'(a_done), 0);
    check("ones_idle", 32'(a_busy), 0);

    // Ramp image 4*row+col
    set_img(1);
    build_a();
    check("model_ramp0", aq[0].sum, 45);
    check("model_ramp1", aq[1].sum, 54);
    check("model_ramp2", aq[2].sum, 81);
    check("model_ramp3", aq[3].sum, 90);
    a_xfers = 0;
    pulse_a_start();
    wait_a_done("ramp_done_timeout", 100);
    @(posedge clk); #1;
    check("ramp_xfers", a_xfers, 4);

    // Seven-cycle stall on the second window
    build_a();
    a_xfers = 0;
    dc0 = a_done_cnt;
    pulse_a_start();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_valid && a_xfers == 1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check("stall_reach_timeout", 0, 1);
    a_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("stall_valid_held", 32'(a_valid), 1);
      check("stall_no_read", 32'(a_rd), 0);
      @(posedge clk); #1;
    end
    a_ready = 1'b1;
    wait_a_done("stall_done_timeout", 100);
    @(posedge clk); #1;
    check("stall_xfers", a_xfers, 4);
    check("stall_queue_empty", aq.size(), 0);
    check("stall_done_once", a_done_cnt - dc0, 1);

    // Abort in ISSUE2 of the first window
    aq.delete();
    dc0 = a_done_cnt;
    pulse_a_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("issue2_rd", 32'(a_rd), 1);
    check("issue2_row", 32'(a_row), 2);
    check("issue2_col", 32'(a_col), 0);
    a_abort = 1'b1;
    @(posedge clk); #1 a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 0);
    check("abort_valid", 32'(a_valid), 0);
    check("abort_rd", 32'(a_rd), 0);
    check("abort_row_held", 32'(a_row), 2);
    repeat (20) @(posedge clk);
    #1 check("abort_no_done", a_done_cnt - dc0, 0);
    check("abort_still_idle", 32'(a_busy), 0);
    build_a();
    a_xfers = 0;
    pulse_a_start();
    wait_a_done("restart_done_timeout", 100);
    @(posedge clk); #1;
    check("restart_xfers", a_xfers, 4);

    // Start while busy is ignored; reset while offering a window
    build_a();
    a_xfers = 0;
    dc0 = a_done_cnt;
    pulse_a_start();
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_xfers == 1) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check("busy_start_reach_timeout", 0, 1);
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check("second_window_timeout", 0, 1);
    a_ready = 1'b0;
    check("busy_start_row", 32'(a_orow), 0);
    check("busy_start_col", 32'(a_ocol), 1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    #1 check_a_reset("mid_rst");
    aq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    a_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("mid_rst_no_done", a_done_cnt - dc0, 0);
    check("mid_rst_idle", 32'(a_busy), 0);

    // 3x3 image: one window, done the cycle after its transfer
    set_img(1);
    bq.delete();
    begin
      win_t e;
      e.sum = win_sum(0, 0);
      e.r = 0;
      e.c = 0;
      bq.push_back(e);
    end
    check("model_3x3", bq[0].sum, 45);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (b_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check("b_done_timeout", 0, 1);
    @(posedge clk); #1;
    check("b_xfers", b_xfers, 1);
    check("b_done_once", b_done_cnt, 1);
    check("b_done_latency", b_done_cyc - b_xfer_cyc, 1);
    check("b_idle", 32'(b_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
